// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared instruction/data memory.
// Runs one registered memory access at a time, round-robin on contention, with a wait-state budget.
module mem_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk_i,
   input  logic          rst_ni,

   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_gnt_o,
   output logic          cpu_done_o,
   output logic          cpu_err_o,
   output logic [DW-1:0] cpu_rdata_o,

   input  logic          dma_req_i,
   input  logic          dma_we_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_wdata_i,
   output logic          dma_gnt_o,
   output logic          dma_done_o,
   output logic          dma_err_o,
   output logic [DW-1:0] dma_rdata_o,

   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ready_i
);

   localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e state_q, state_d;

   // Port index 0 is the CPU, 1 is the DMA/loader.
   logic                  own_q, own_d;
   logic                  last_q, last_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [AW-1:0]         mem_addr_q, mem_addr_d;
   logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            done_q, done_d;
   logic [1:0]            err_q, err_d;
   logic [1:0][DW-1:0]    rdata_q, rdata_d;

   logic                  any_req;
   logic                  win;
   logic                  busy_end;
   logic                  busy_timeout;
   logic [DW-1:0]         done_rdata;

   assign any_req      = cpu_req_i | dma_req_i;
   // On a tie the port that did not win last time goes next.
   assign win          = (cpu_req_i & dma_req_i) ? ~last_q : dma_req_i;
   assign busy_timeout = ~mem_ready_i & (cnt_q == CntLast);
   assign busy_end     = mem_ready_i | busy_timeout;
   assign done_rdata   = mem_ready_i ? mem_rdata_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StBusy;
         StBusy:  if (busy_end) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      own_d       = own_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      gnt_d       = gnt_q;
      done_d      = done_q;
      err_d       = err_q;
      rdata_d     = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               own_d       = win;
               last_d      = win;
               cnt_d       = '0;
               mem_en_d    = 1'b1;
               mem_we_d    = win ? dma_we_i    : cpu_we_i;
               mem_addr_d  = win ? dma_addr_i  : cpu_addr_i;
               mem_wdata_d = win ? dma_wdata_i : cpu_wdata_i;
               gnt_d       = '0;
               gnt_d[win]  = 1'b1;
            end
         end
         StBusy: begin
            if (busy_end) begin
               mem_en_d      = 1'b0;
               done_d[own_q] = 1'b1;
               err_d[own_q]  = busy_timeout;
               // An aborted read returns zero so stale data is never mistaken for a result.
               if (!mem_we_q) rdata_d[own_q] = done_rdata;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            done_d = '0;
            err_d  = '0;
            gnt_d  = '0;
         end
         default: begin
            mem_en_d = 1'b0;
            done_d   = '0;
            err_d    = '0;
            gnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         own_q       <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rdata_q     <= '0;
      end else begin
         own_q       <= own_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign cpu_gnt_o   = gnt_q[0];
   assign dma_gnt_o   = gnt_q[1];
   assign cpu_done_o  = done_q[0];
   assign dma_done_o  = done_q[1];
   assign cpu_err_o   = err_q[0];
   assign dma_err_o   = err_q[1];
   assign cpu_rdata_o = rdata_q[0];
   assign dma_rdata_o = rdata_q[1];
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

`ifndef SYNTHESIS
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_q));
   a_en_busy    : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   mem_en_q == (state_q == StBusy));
   a_err_done   : assert property (@(posedge clk_i) disable iff (!rst_ni) (err_q & ~done_q) == '0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts winner, latency,
// error and read data for each access while the bench plays both requesters and the memory.
module tb_mem_arbiter;

   localparam int unsigned AW      = 32;
   localparam int unsigned DW      = 32;
   localparam int unsigned TIMEOUT = 15;

   logic          clk_i, rst_ni;
   logic          cpu_req_i, cpu_we_i, dma_req_i, dma_we_i;
   logic [AW-1:0] cpu_addr_i, dma_addr_i;
   logic [DW-1:0] cpu_wdata_i, dma_wdata_i;
   logic          cpu_gnt_o, cpu_done_o, cpu_err_o, dma_gnt_o, dma_done_o, dma_err_o;
   logic [DW-1:0] cpu_rdata_o, dma_rdata_o;
   logic          mem_en_o, mem_we_o, mem_ready_i;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o, mem_rdata_i;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_gnt_o   (cpu_gnt_o),
      .cpu_done_o  (cpu_done_o),
      .cpu_err_o   (cpu_err_o),
      .cpu_rdata_o (cpu_rdata_o),
      .dma_req_i   (dma_req_i),
      .dma_we_i    (dma_we_i),
      .dma_addr_i  (dma_addr_i),
      .dma_wdata_i (dma_wdata_i),
      .dma_gnt_o   (dma_gnt_o),
      .dma_done_o  (dma_done_o),
      .dma_err_o   (dma_err_o),
      .dma_rdata_o (dma_rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Reference model: pending request per port, round-robin memory, expected read data.
   logic          p_vld   [2];
   logic          p_we    [2];
   logic [AW-1:0] p_addr  [2];
   logic [DW-1:0] p_wdata [2];
   logic [DW-1:0] exp_rdata [2];
   int            last_win;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_req();
      cpu_req_i   = p_vld[0];
      cpu_we_i    = p_we[0];
      cpu_addr_i  = p_addr[0];
      cpu_wdata_i = p_wdata[0];
      dma_req_i   = p_vld[1];
      dma_we_i    = p_we[1];
      dma_addr_i  = p_addr[1];
      dma_wdata_i = p_wdata[1];
   endtask

   task automatic set_req(input int port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
      p_vld[port]   = 1'b1;
      p_we[port]    = we;
      p_addr[port]  = addr;
      p_wdata[port] = wdata;
   endtask

   task automatic gen_reqs();
      for (int i = 0; i < 2; i++) begin
         if (!p_vld[i] && $urandom_range(0, 9) < 7)
            set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) return 0;
      if (r < 7) return $urandom_range(1, 4);
      if (r == 7) return TIMEOUT - 1;
      if (r == 8) return TIMEOUT;
      return 1000;
   endfunction

   task automatic check_quiet_outputs(input string tag);
      check({tag, "_en"},   mem_en_o, 0);
      check({tag, "_gnt"},  {cpu_gnt_o, dma_gnt_o}, 0);
      check({tag, "_done"}, {cpu_done_o, dma_done_o}, 0);
      check({tag, "_err"},  {cpu_err_o, dma_err_o}, 0);
   endtask

   // Starts in an IDLE cycle; memory raises ready in BUSY cycle number wt (0-based).
   task automatic run_access(input int wt, input logic [DW-1:0] rd);
      int            win;
      logic          exp_err;
      logic          g_we;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_wdata;

      apply_req();
      mem_ready_i = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      if (!p_vld[0] && !p_vld[1]) begin
         tick();
         check_quiet_outputs("idle");
         return;
      end
      if (p_vld[0] && p_vld[1]) win = (last_win == 0) ? 1 : 0;
      else                      win = p_vld[1] ? 1 : 0;
      last_win   = win;
      g_we       = p_we[win];
      g_addr     = p_addr[win];
      g_wdata    = p_wdata[win];
      p_vld[win] = 1'b0;
      exp_err    = (wt > int'(TIMEOUT) - 1);

      tick();
      for (int k = 0; k < int'(TIMEOUT); k++) begin
         check("busy_en",    mem_en_o, 1);
         check("busy_we",    mem_we_o, g_we);
         check("busy_addr",  mem_addr_o, g_addr);
         check("busy_wdata", mem_wdata_o, g_wdata);
         check("busy_gnt",   {dma_gnt_o, cpu_gnt_o}, (win == 1) ? 2'b10 : 2'b01);
         check("busy_done",  {cpu_done_o, dma_done_o}, 0);
         mem_ready_i = (k == wt);
         mem_rdata_i = (k == wt) ? rd : $urandom;
         if ($urandom_range(0, 7) == 0) begin
            if (win == 0) begin
               cpu_req_i = 1'b0; cpu_we_i = ~cpu_we_i; cpu_addr_i = $urandom;
            end else begin
               dma_req_i = 1'b0; dma_we_i = ~dma_we_i; dma_addr_i = $urandom;
            end
         end
         tick();
         if (k == wt || k == int'(TIMEOUT) - 1) break;
      end

      if (!g_we) exp_rdata[win] = exp_err ? '0 : rd;
      check("done_cpu",  cpu_done_o, win == 0);
      check("done_dma",  dma_done_o, win == 1);
      check("err_cpu",   cpu_err_o, (win == 0) && exp_err);
      check("err_dma",   dma_err_o, (win == 1) && exp_err);
      check("done_gnt",  {dma_gnt_o, cpu_gnt_o}, (win == 1) ? 2'b10 : 2'b01);
      check("done_en",   mem_en_o, 0);
      check("hold_addr", mem_addr_o, g_addr);
      check("hold_we",   mem_we_o, g_we);
      check("rdata_cpu", cpu_rdata_o, exp_rdata[0]);
      check("rdata_dma", dma_rdata_o, exp_rdata[1]);
      mem_ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) gen_reqs();
      apply_req();
      tick();
      check_quiet_outputs("post");
   endtask

   initial begin
      rst_ni      = 1'b0;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      for (int i = 0; i < 2; i++) begin
         p_vld[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
         exp_rdata[i] = '0;
      end
      last_win = 1;
      apply_req();
      tick();
      tick();
      check_quiet_outputs("rst");
      check("rst_we",    mem_we_o, 0);
      check("rst_addr",  mem_addr_o, 0);
      check("rst_wdata", mem_wdata_o, 0);
      check("rst_rdata", {cpu_rdata_o, dma_rdata_o}, 0);
      rst_ni = 1'b1;

      set_req(0, 1'b0, 32'h40, 32'h0);
      run_access(0, 32'hDEADBEEF);
      set_req(1, 1'b1, 32'h100, 32'h12345678);
      run_access(3, $urandom);
      for (int n = 0; n < 4; n++) begin
         if (!p_vld[0]) set_req(0, 1'b0, $urandom, $urandom);
         if (!p_vld[1]) set_req(1, 1'b0, $urandom, $urandom);
         run_access(0, $urandom);
      end
      p_vld[0] = 1'b0;
      p_vld[1] = 1'b0;
      set_req(0, 1'b0, $urandom, $urandom);
      run_access(1000, $urandom);
      set_req(0, 1'b0, $urandom, $urandom);
      run_access(TIMEOUT - 1, $urandom);

      for (int n = 0; n < 300; n++) begin
         gen_reqs();
         run_access(pick_wait(), $urandom);
      end

      // Reset in the second BUSY cycle of a DMA read, request kept high across it.
      p_vld[0] = 1'b0;
      set_req(1, 1'b0, $urandom, $urandom);
      apply_req();
      mem_ready_i = 1'b0;
      tick();
      check("mid_gnt", dma_gnt_o, 1);
      tick();
      #2 rst_ni = 1'b0;
      #1;
      check("arst_en",  mem_en_o, 0);
      check("arst_gnt", dma_gnt_o, 0);
      tick();
      check_quiet_outputs("arst_hold");
      #2 rst_ni = 1'b1;
      last_win     = 1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      check("arst_rdata", {cpu_rdata_o, dma_rdata_o}, 0);
      run_access(0, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
